// File: rtl/array_7_ctrl_if.sv
// Requester-side bundle of array_7_ctrl: two read ports, one write port,
// the response queue head and the zero-fill status.
interface array_7_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 160
);
  logic              rd0_valid;
  logic              rd0_ready;
  logic [ADDR_W-1:0] rd0_addr;
  logic              rd1_valid;
  logic              rd1_ready;
  logic [ADDR_W-1:0] rd1_addr;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_id;
  logic              init_done;

  modport master (
    output rd0_valid, rd0_addr, rd1_valid, rd1_addr,
    output wr_valid, wr_addr, wr_data, resp_ready,
    input  rd0_ready, rd1_ready, wr_ready,
    input  resp_valid, resp_data, resp_id, init_done
  );

  modport slave (
    input  rd0_valid, rd0_addr, rd1_valid, rd1_addr,
    input  wr_valid, wr_addr, wr_data, resp_ready,
    output rd0_ready, rd1_ready, wr_ready,
    output resp_valid, resp_data, resp_id, init_done
  );
endinterface

// File: rtl/array_7_ctrl.sv
// Front-end for a 1R1W array macro: zero-fills after reset, round-robins two
// readers onto the read port and returns read data through an in-order queue.
module array_7_ctrl #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 160,
  parameter int DEPTH      = 64,
  parameter int RESP_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  array_7_ctrl_if.slave     io,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [DATA_W-1:0] W0_data,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [DATA_W-1:0] R0_data
);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1) + 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_rr;
  logic              r_inflight, r_inflight_id;
  logic              r_byp_hit;
  logic [DATA_W-1:0] r_byp_data;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [DATA_W-1:0] r_q_data [RESP_DEPTH];
  logic              r_q_id   [RESP_DEPTH];

  logic              w_gnt_vld, w_gnt_id, w_allow;
  logic              w_push, w_pop;
  logic [CW-1:0]     w_occ;
  logic [DATA_W-1:0] w_push_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts the in-flight read; a same-cycle pop is deliberately ignored
  // so resp_ready never reaches the read readys combinationally.
  assign w_occ   = r_count + CW'(r_inflight);
  assign w_allow = (r_state == S_RUN) && (w_occ < CW'(RESP_DEPTH));

  always_comb begin
    w_state_nxt  = r_state;
    W0_en        = 1'b0;
    W0_addr      = io.wr_addr;
    W0_data      = io.wr_data;
    R0_en        = 1'b0;
    R0_addr      = io.rd0_addr;
    w_gnt_vld    = 1'b0;
    w_gnt_id     = 1'b0;
    io.rd0_ready = 1'b0;
    io.rd1_ready = 1'b0;
    case (r_state)
      S_INIT: begin
        W0_en   = 1'b1;
        W0_addr = r_cnt;
        W0_data = '0;
        if (r_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        W0_en = io.wr_valid;
        if (w_allow && (io.rd0_valid || io.rd1_valid)) begin
          w_gnt_vld    = 1'b1;
          w_gnt_id     = (io.rd0_valid && io.rd1_valid) ? r_rr : io.rd1_valid;
          R0_en        = 1'b1;
          R0_addr      = w_gnt_id ? io.rd1_addr : io.rd0_addr;
          io.rd0_ready = !w_gnt_id;
          io.rd1_ready = w_gnt_id;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  // A write to the address being read this cycle must win, whatever the macro does.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr          <= 1'b0;
      r_inflight    <= 1'b0;
      r_inflight_id <= 1'b0;
      r_byp_hit     <= 1'b0;
    end else begin
      r_inflight    <= w_gnt_vld;
      r_inflight_id <= w_gnt_id;
      r_byp_hit     <= w_gnt_vld && W0_en && (W0_addr == R0_addr);
      if (w_gnt_vld) r_rr <= ~w_gnt_id;
    end
  end

  always_ff @(posedge clock) begin
    if (w_gnt_vld && W0_en) r_byp_data <= W0_data;
  end

  assign w_push      = r_inflight;
  assign w_pop       = io.resp_valid && io.resp_ready;
  assign w_push_data = r_byp_hit ? r_byp_data : R0_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_data[r_wptr] <= w_push_data;
      r_q_id[r_wptr]   <= r_inflight_id;
    end
  end

  assign io.resp_valid = (r_count != '0);
  assign io.resp_data  = r_q_data[r_rptr];
  assign io.resp_id    = r_q_id[r_rptr];
  assign io.init_done  = (r_state == S_RUN);
  assign io.wr_ready   = (r_state == S_RUN);
endmodule

// File: tb/tb_array_7_ctrl.sv
// Randomized bench for array_7_ctrl: a behavioural array/queue model predicts
// readys, response order, data and timing each cycle.
module tb_array_7_ctrl;
  localparam int AW = 6, DW = 160, DEPTH = 64, RD = 3;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  array_7_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) io();
  logic [AW-1:0] W0_addr, R0_addr;
  logic          W0_en, R0_en;
  logic [DW-1:0] W0_data, R0_data;

  array_7_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESP_DEPTH(RD)) dut (
    .clock(clk), .reset(rst), .io(io),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data));

  // Macro model: read-before-write on a same-address collision.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (W0_en) mem[W0_addr] <= W0_data;
    if (R0_en) R0_data <= mem[R0_addr];
  end

  typedef struct { logic id; logic [DW-1:0] data; int acc; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            cyc;
  logic          last_g;
  int            n_chk = 0, n_pass = 0;
  int            m_outst;
  bit            m_allow, m_g;
  exp_t          m_e;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0; else cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      last_g = 1'b1;
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else if (cyc < DEPTH) begin
      chk("init_done_lo", io.init_done, 0);
      chk("init_w0_en", W0_en, 1);
      chk("init_w0_addr", W0_addr, cyc);
      chk("init_w0_data", W0_data, 0);
      chk("init_quiet", {io.rd0_ready, io.rd1_ready, io.wr_ready, R0_en, io.resp_valid}, 0);
    end else begin
      chk("init_done", io.init_done, 1);
      chk("wr_ready", io.wr_ready, 1);
      chk("w0_en", W0_en, io.wr_valid);
      if (io.wr_valid) begin
        chk("w0_addr", W0_addr, io.wr_addr);
        chk("w0_data", W0_data, io.wr_data);
      end
      m_outst = sb.size();
      chk("resp_valid", io.resp_valid, (m_outst > 0) && (cyc >= sb[0].acc + 2));
      if (io.resp_valid && m_outst > 0) begin
        chk("resp_data", io.resp_data, sb[0].data);
        chk("resp_id", io.resp_id, sb[0].id);
        if (io.resp_ready) void'(sb.pop_front());
      end
      if (io.wr_valid) ref_mem[io.wr_addr] = io.wr_data;
      m_allow = (m_outst < RD) && (io.rd0_valid || io.rd1_valid);
      m_g = (io.rd0_valid && io.rd1_valid) ? ~last_g : io.rd1_valid;
      chk("rd0_ready", io.rd0_ready, m_allow && !m_g);
      chk("rd1_ready", io.rd1_ready, m_allow && m_g);
      chk("r0_en", R0_en, m_allow);
      if (m_allow) begin
        m_e.id   = m_g;
        m_e.data = ref_mem[m_g ? io.rd1_addr : io.rd0_addr];
        m_e.acc  = cyc;
        sb.push_back(m_e);
        last_g = m_g;
      end
    end
  end

  task automatic drv(input bit v0, input logic [AW-1:0] a0, input bit v1, input logic [AW-1:0] a1,
                     input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input bit rr, input int n);
    io.rd0_valid = v0; io.rd0_addr = a0;
    io.rd1_valid = v1; io.rd1_addr = a1;
    io.wr_valid  = wv; io.wr_addr  = wa; io.wr_data = wd;
    io.resp_ready = rr;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0, '0, 1, n);
  endtask

  logic [DW-1:0] x_val, y_val;

  initial begin
    foreach (mem[i]) mem[i] = rnd_data();
    drv(1, 1, 1, 2, 0, 0, '0, 1, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // Valids held high through the sweep: no ready may appear.
    drv(1, 1, 1, 2, 0, 0, '0, 1, DEPTH);
    idle(3);
    drv(1, 37, 0, 0, 0, 0, '0, 1, 1);
    idle(4);
    drv(0, 0, 0, 0, 1, 5, {20{8'hA5}}, 1, 1);
    drv(1, 5, 0, 0, 0, 0, '0, 1, 1);
    idle(4);
    drv(1, 5, 1, 37, 0, 0, '0, 1, 10);
    idle(3);
    drv(1, 5, 1, 9, 0, 0, '0, 0, 6);
    drv(1, 5, 1, 9, 0, 0, '0, 1, 8);
    idle(4);
    x_val = rnd_data();
    y_val = rnd_data();
    drv(1, 9, 0, 0, 1, 9, x_val, 1, 1);
    idle(3);
    drv(0, 0, 1, 9, 0, 0, '0, 1, 1);
    drv(0, 0, 0, 0, 1, 9, y_val, 1, 1);
    idle(4);
    drv(1, 9, 0, 0, 0, 0, '0, 1, 1);
    idle(4);
    drv(1, 9, 1, 5, 0, 0, '0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, '0, 0, 3);
    chk("pre_reset_valid", io.resp_valid, 1);
    rst = 1'b1;
    #1 chk("reset_drops_valid", io.resp_valid, 0);
    drv(0, 0, 0, 0, 0, 0, '0, 1, 2);
    rst = 1'b0;
    drv(1, 9, 1, 5, 0, 0, '0, 1, DEPTH + 2);
    idle(4);
    for (int i = 0; i < 2000; i++)
      drv($urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom_range(0, 1),
          AW'($urandom_range(0, 7)), $urandom_range(0, 1), AW'($urandom_range(0, 7)),
          rnd_data(), $urandom_range(0, 3) != 0, 1);
    idle(8);
    chk("drain_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
